// File: rtl/mac_dot_scheduler.sv
// mac_dot_scheduler
// Feeds one shared FP64 MAC pipeline so that it computes NUM_ACC independent
// dot products of length len_cfg. Input pairs are spread round-robin over
// NUM_ACC accumulator slots. The gap between two issues to the same slot is
// then longer than the MAC's C-to-result latency. Each slot's running sum is
// supplied on mac_c C_DLY cycles after issue, and the MAC result is written
// back RES_DLY cycles after issue. Finished sums are streamed out in slot order.
//
// Optional build macro MAC_SCHED_PERF_EN adds the perf_cycles and perf_stalls
// counter outputs. Without it, those ports and counters do not exist.
//
// Parameter constraints: NUM_ACC must be a power of two and at least 7.
// C_DLY must be at least 1, and RES_DLY must be greater than C_DLY.

module mac_dot_scheduler #(
    parameter int  NUM_ACC = 8,
    parameter int  LEN_W   = 16,
    parameter int  C_DLY   = 4,
    parameter int  RES_DLY = 11,
    localparam int SLOT_W  = $clog2(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst,
    // job control
    input  logic              start,
    input  logic [LEN_W-1:0]  len_cfg,
    output logic              busy,
    output logic              done,
    // operand stream from the tile fetch logic
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_a,
    input  logic [63:0]       in_b,
    // shared MAC pipeline
    output logic              mac_valid,
    output logic [63:0]       mac_ta,
    output logic [63:0]       mac_tb,
    output logic [63:0]       mac_c,
    input  logic [63:0]       mac_res,
    input  logic              mac_store_valid,
    input  logic              mac_error,
    // result stream to the writer
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic [SLOT_W-1:0] out_idx,
`ifdef MAC_SCHED_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls,
`endif
    output logic              err_sticky
);

    // Pair counter: holds up to NUM_ACC * (2**LEN_W - 1) pairs.
    localparam int CNT_W = LEN_W + SLOT_W;
    // In-flight counter: holds at least RES_DLY + 1 outstanding issues.
    localparam int IF_W  = $clog2(RES_DLY + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // job bookkeeping
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  total_m1;
    logic [SLOT_W-1:0] slot_ptr;
    logic [SLOT_W-1:0] issue_slot;
    logic [SLOT_W-1:0] out_ptr;
    logic [IF_W-1:0]   in_flight;

    // accumulator slot buffer
    logic [63:0]       acc_buf [NUM_ACC];

    // slot tracking for the C-sample and result-write points
    logic              c_vld_sr  [C_DLY];
    logic [SLOT_W-1:0] c_slot_sr [C_DLY];
    logic [SLOT_W-1:0] r_slot_sr [RES_DLY];

    // decoded control
    logic              start_accept;
    logic              accept;
    logic              last_accept;
    logic              out_hs;
    logic              out_last;
    logic              store_write;
    logic              store_spurious;
    logic [SLOT_W-1:0] w_slot;
    logic [SLOT_W-1:0] c_slot;
    logic              c_active;

    assign total_m1       = {len_q, {SLOT_W{1'b0}}} - CNT_W'(1);
    assign store_write    = mac_store_valid && (in_flight != '0);
    assign store_spurious = mac_store_valid && (in_flight == '0);
    assign w_slot         = r_slot_sr[RES_DLY-1];
    assign c_slot         = c_slot_sr[C_DLY-1];
    assign c_active       = c_vld_sr[C_DLY-1];
    assign out_data       = acc_buf[out_ptr];
    assign out_idx        = out_ptr;

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and handshake outputs.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        busy         = 1'b1;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        start_accept = 1'b0;
        accept       = 1'b0;
        last_accept  = 1'b0;
        out_hs       = 1'b0;
        out_last     = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = (len_cfg == '0) ? S_OUTPUT : S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (acc_cnt == total_m1)) begin
                    last_accept = 1'b1;
                    state_next  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The registered issue (mac_valid) is not yet in in_flight.
                if ((in_flight == '0) && !mac_valid) state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                out_hs    = out_ready;
                if (out_ready && (out_ptr == SLOT_W'(NUM_ACC - 1))) begin
                    out_last   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Job setup, pair issue, output pointer, done pulse and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            acc_cnt    <= '0;
            slot_ptr   <= '0;
            issue_slot <= '0;
            out_ptr    <= '0;
            mac_valid  <= 1'b0;
            mac_ta     <= '0;
            mac_tb     <= '0;
            done       <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            done <= out_last;
            if (start_accept) begin
                len_q    <= len_cfg;
                acc_cnt  <= '0;
                slot_ptr <= '0;
                out_ptr  <= '0;
            end
            if (accept) begin
                mac_valid  <= 1'b1;
                mac_ta     <= in_a;
                mac_tb     <= in_b;
                issue_slot <= slot_ptr;
                slot_ptr   <= slot_ptr + SLOT_W'(1);
                acc_cnt    <= acc_cnt + CNT_W'(1);
            end else begin
                mac_valid <= 1'b0;
            end
            // out_ptr wraps back to 0 on the final handshake.
            if (out_hs) out_ptr <= out_ptr + SLOT_W'(1);
            if (start_accept)                         err_sticky <= 1'b0;
            else if ((busy && mac_error) || store_spurious) err_sticky <= 1'b1;
        end
    end

    // Outstanding MAC operations: +1 on issue, -1 on an accepted store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (mac_valid && !store_write) begin
            in_flight <= in_flight + IF_W'(1);
        end else if (!mac_valid && store_write) begin
            in_flight <= in_flight - IF_W'(1);
        end
    end

    // Slot indices ride alongside the MAC pipeline to the C and result points.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_DLY; i++) begin
                c_vld_sr[i]  <= 1'b0;
                c_slot_sr[i] <= '0;
            end
            for (int i = 0; i < RES_DLY; i++) r_slot_sr[i] <= '0;
        end else begin
            c_vld_sr[0]  <= mac_valid;
            c_slot_sr[0] <= issue_slot;
            for (int i = 1; i < C_DLY; i++) begin
                c_vld_sr[i]  <= c_vld_sr[i-1];
                c_slot_sr[i] <= c_slot_sr[i-1];
            end
            r_slot_sr[0] <= issue_slot;
            for (int i = 1; i < RES_DLY; i++) r_slot_sr[i] <= r_slot_sr[i-1];
        end
    end

    // Slot buffer: cleared at job start, updated by MAC stores.
    // NOTE: the buffer is a small flop array, not a RAM macro, so it takes the
    // async reset. A job that follows an abort then never reads stale sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) acc_buf[i] <= '0;
        end else if (start_accept) begin
            for (int i = 0; i < NUM_ACC; i++) acc_buf[i] <= '0;
        end else if (store_write) begin
            acc_buf[w_slot] <= mac_res;
        end
    end

    // C supply. A store to the same slot in this cycle is forwarded directly.
    always_comb begin
        mac_c = '0;
        if (c_active) begin
            if (store_write && (w_slot == c_slot)) mac_c = mac_res;
            else                                   mac_c = acc_buf[c_slot];
        end
    end

`ifdef MAC_SCHED_PERF_EN
    // Job cycle and input-starvation counters; cleared on start, frozen after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (in_ready && !in_valid) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Testbench for mac_dot_scheduler. A behavioural FP64 MAC model answers
// issues with the C_DLY / RES_DLY timing. Per-slot expected sums are
// accumulated while pairs are driven and queued for comparison against the
// output stream.

module tb_mac_dot_scheduler;

    localparam int NUM_ACC = 8;
    localparam int LEN_W   = 16;
    localparam int C_DLY   = 4;
    localparam int RES_DLY = 11;
    localparam int SLOT_W  = 3;
    localparam int RING    = 32;

    localparam logic [63:0] F1 = 64'h3FF0000000000000;  // 1.0
    localparam logic [63:0] F2 = 64'h4000000000000000;  // 2.0
    localparam logic [63:0] F3 = 64'h4008000000000000;  // 3.0

    typedef struct packed {
        logic [SLOT_W-1:0] idx;
        logic [63:0]       data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len_cfg;
    logic              busy, done;
    logic              in_valid, in_ready;
    logic [63:0]       in_a, in_b;
    logic              mac_valid;
    logic [63:0]       mac_ta, mac_tb, mac_c, mac_res;
    logic              mac_store_valid, mac_error;
    logic              out_valid, out_ready;
    logic [63:0]       out_data;
    logic [SLOT_W-1:0] out_idx;
    logic              err_sticky;

    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   issue_cnt = 0;
    int   cyc       = 0;
    int   pair_no   = 0;
    real  exp_sum [NUM_ACC];
    exp_t exp_q[$];

    // MAC model state, indexed by issue cycle modulo RING
    logic [63:0] m_a [RING];
    logic [63:0] m_b [RING];
    logic [63:0] m_r [RING];
    bit          m_v [RING];
    int          ri, ci;

    always #5 clk = ~clk;

    mac_dot_scheduler #(
        .NUM_ACC (NUM_ACC),
        .LEN_W   (LEN_W),
        .C_DLY   (C_DLY),
        .RES_DLY (RES_DLY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .len_cfg         (len_cfg),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .mac_valid       (mac_valid),
        .mac_ta          (mac_ta),
        .mac_tb          (mac_tb),
        .mac_c           (mac_c),
        .mac_res         (mac_res),
        .mac_store_valid (mac_store_valid),
        .mac_error       (mac_error),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_idx         (out_idx),
        .err_sticky      (err_sticky)
    );

    // Behavioural MAC: records issues, samples C at +C_DLY, stores at +RES_DLY.
    initial begin
        mac_store_valid = 1'b0;
        mac_res         = '0;
        for (int i = 0; i < RING; i++) m_v[i] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ri = (cyc - RES_DLY) % RING;
            if (rst) begin
                for (int i = 0; i < RING; i++) m_v[i] = 1'b0;
                mac_store_valid = 1'b0;
                mac_res         = '0;
            end else if (cyc >= RES_DLY && m_v[ri]) begin
                mac_store_valid = 1'b1;
                mac_res         = m_r[ri];
                m_v[ri]         = 1'b0;
            end else begin
                mac_store_valid = 1'b0;
                mac_res         = '0;
            end
            @(negedge clk);
            if (!rst) begin
                if (mac_valid === 1'b1) begin
                    m_v[cyc % RING] = 1'b1;
                    m_a[cyc % RING] = mac_ta;
                    m_b[cyc % RING] = mac_tb;
                    issue_cnt++;
                end
                ci = (cyc - C_DLY) % RING;
                if (cyc >= C_DLY && m_v[ci])
                    m_r[ci] = $realtobits($bitstoreal(m_a[ci]) * $bitstoreal(m_b[ci])
                                          + $bitstoreal(mac_c));
            end
        end
    end

    // Count done pulses.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Hard stop if anything hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        for (int k = 0; k < NUM_ACC; k++) exp_sum[k] = 0.0;
        pair_no  = 0;
        done_cnt = 0;
        start    = 1'b1;
        len_cfg  = LEN_W'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic send_pair(input logic [63:0] a, input logic [63:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_pair_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_sum[pair_no % NUM_ACC] += $bitstoreal(a) * $bitstoreal(b);
        pair_no++;
    endtask

    task automatic push_expected();
        for (int k = 0; k < NUM_ACC; k++)
            exp_q.push_back({SLOT_W'(k), $realtobits(exp_sum[k])});
    endtask

    // Pop scoreboard entries on each output handshake; optionally stall one slot.
    task automatic collect_outputs(input int stall_idx, input int stall_n);
        int got = 0;
        int t = 0;
        int held = 0;
        logic [63:0]       hd = '0;
        logic [SLOT_W-1:0] hi = '0;
        exp_t e;
        while (got < NUM_ACC && t < 3000) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (int'(out_idx) == stall_idx && held < stall_n) begin
                    if (held == 0) begin
                        hd = out_data;
                        hi = out_idx;
                    end else begin
                        checks++;
                        if (out_data !== hd || out_idx !== hi) begin
                            failures++;
                            $display("FAIL hold_stable: idx=%0d data=%h required idx=%0d data=%h",
                                     out_idx, out_data, hi, hd);
                        end
                    end
                    out_ready = 1'b0;
                    held++;
                end else begin
                    out_ready = 1'b1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected: idx=%0d data=%h required no output",
                                 out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_idx !== e.idx || out_data !== e.data) begin
                            failures++;
                            $display("FAIL out_data: idx=%0d data=%h required idx=%0d data=%h",
                                     out_idx, out_data, e.idx, e.data);
                        end
                    end
                    got++;
                end
            end else begin
                out_ready = 1'b0;
            end
            t++;
        end
        if (got < NUM_ACC) begin
            checks++;
            failures++;
            $display("FAIL out_timeout: got %0d outputs required %0d", got, NUM_ACC);
        end
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; len_cfg = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; mac_error = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, in_ready, mac_valid, out_valid, err_sticky} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/in_ready/mac_valid/out_valid/err=%b required 000000",
                     {busy, done, in_ready, mac_valid, out_valid, err_sticky});
        end
        checks++;
        if ({mac_ta, mac_tb, mac_c, out_data} !== 256'b0 || out_idx !== '0) begin
            failures++;
            $display("FAIL reset_data: ta=%h tb=%h c=%h out=%h idx=%0d required all 0",
                     mac_ta, mac_tb, mac_c, out_data, out_idx);
        end
    endtask

    task automatic test_basic();
        int i0 = issue_cnt;
        start_job(1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: busy=%b required 1", busy);
        end
        for (int p = 0; p < NUM_ACC; p++) send_pair(F1, F2, 0);
        push_expected();
        collect_outputs(-1, 0);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done pulses=%0d busy=%b required 1 and 0", done_cnt, busy);
        end
        checks++;
        if (err_sticky !== 1'b0 || issue_cnt - i0 != NUM_ACC) begin
            failures++;
            $display("FAIL basic_err_issues: err=%b issues=%0d required 0 and %0d",
                     err_sticky, issue_cnt - i0, NUM_ACC);
        end
    endtask

    task automatic test_stalls();
        start_job(2);
        for (int p = 0; p < 2 * NUM_ACC; p++)
            send_pair(F1, F3, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        push_expected();
        collect_outputs(-1, 0);
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL stalls_done: done pulses=%0d required 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        start_job(4);
        for (int p = 0; p < 4 * NUM_ACC; p++) send_pair(F2, F2, 0);
        push_expected();
        collect_outputs(-1, 0);
        checks++;
        if (done_cnt != 1 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: done pulses=%0d err=%b required 1 and 0", done_cnt, err_sticky);
        end
    endtask

    task automatic test_zero_len();
        int i0 = issue_cnt;
        start_job(0);
        push_expected();
        collect_outputs(-1, 0);
        checks++;
        if (issue_cnt != i0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_len: issues=%0d done pulses=%0d required 0 and 1",
                     issue_cnt - i0, done_cnt);
        end
    endtask

    task automatic test_backpressure_error();
        start_job(1);
        for (int p = 0; p < NUM_ACC; p++) begin
            if (p == 4) mac_error = 1'b1;
            send_pair($realtobits(real'(p) + 1.0), 64'h3FE0000000000000, 0);
            mac_error = 1'b0;
        end
        push_expected();
        collect_outputs(3, 5);
        checks++;
        if (err_sticky !== 1'b1 || done_cnt != 1) begin
            failures++;
            $display("FAIL err_sticky_set: err=%b done pulses=%0d required 1 and 1",
                     err_sticky, done_cnt);
        end
        repeat (4) tick();
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky_hold: err=%b required 1", err_sticky);
        end
    endtask

    task automatic test_reset_mid_run();
        start_job(2);
        checks++;
        if (err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start: err=%b required 0", err_sticky);
        end
        for (int p = 0; p < 5; p++) send_pair(F1, F2, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, in_ready, mac_valid, out_valid, err_sticky} !== 6'b0 ||
            {mac_ta, mac_tb, mac_c, out_data} !== 256'b0 || out_idx !== '0) begin
            failures++;
            $display("FAIL abort_reset: ctrl=%b ta=%h tb=%h c=%h out=%h idx=%0d required all 0",
                     {busy, done, in_ready, mac_valid, out_valid, err_sticky},
                     mac_ta, mac_tb, mac_c, out_data, out_idx);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        start_job(1);
        for (int p = 0; p < NUM_ACC; p++) send_pair(F1, F2, 0);
        push_expected();
        collect_outputs(-1, 0);
        checks++;
        if (done_cnt != 1 || err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL after_abort: done pulses=%0d err=%b required 1 and 0", done_cnt, err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_back_to_back();
        test_zero_len();
        test_backpressure_error();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
